// File: rtl/mem_range_comparator.sv
// mem_range_comparator
//   Two-stage pipelined address-window checker. Each accepted address is
//   compared against NUM_CH programmable inclusive windows [lo, hi]. The
//   result reports per-window hit, below-window (lt) and above-window (gt)
//   flags, the lowest-index hit, a miss flag, and keeps a saturating count
//   of delivered misses.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   cfg_we/cfg_ch     write strobe and window index
//   cfg_lo/cfg_hi     inclusive window bounds
//   cfg_en            window enable
//   in_valid/in_ready address stream handshake
//   in_addr           address to check
//   out_valid/out_ready result stream handshake
//   out_hit           per-window hit (enabled and inside bounds)
//   out_lt/out_gt     address below lo / above hi, independent of enable
//   out_first         lowest-index hit, 0 on a miss
//   out_miss          no enabled window hit
//   viol_clr          synchronous clear of viol_cnt
//   viol_cnt          saturating count of delivered miss results

module mem_range_comparator #(
    parameter int DATA_W      = 16,
    parameter int NUM_CH      = 4,
    parameter int SIGNED_MODE = 0,
    parameter int CNT_W       = 8,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DATA_W-1:0] cfg_lo,
    input  logic [DATA_W-1:0] cfg_hi,
    input  logic              cfg_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NUM_CH-1:0] out_hit,
    output logic [NUM_CH-1:0] out_lt,
    output logic [NUM_CH-1:0] out_gt,
    output logic [CH_W-1:0]   out_first,
    output logic              out_miss,
    input  logic              viol_clr,
    output logic [CNT_W-1:0]  viol_cnt
);

    // Magnitude compare a < b, two's-complement when SIGNED_MODE is set.
    function automatic logic less_than(input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        sa = a;
        sb = b;
        if (SIGNED_MODE != 0)
            return sa < sb;
        return a < b;
    endfunction

    // Saturating increment: holds at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        return v + CNT_W'(1);
    endfunction

    logic [DATA_W-1:0] win_lo [NUM_CH];
    logic [DATA_W-1:0] win_hi [NUM_CH];
    logic [NUM_CH-1:0] win_en;

    logic              vld_p1;
    logic              vld_p2;
    logic [DATA_W-1:0] addr_p1;
    logic              adv_p1;
    logic              adv_p2;

    logic [NUM_CH-1:0] lt_c;
    logic [NUM_CH-1:0] gt_c;
    logic [NUM_CH-1:0] hit_c;
    logic [CH_W-1:0]   first_c;
    logic              miss_c;

    // Elastic handshake: a stage may load when empty or when the stage
    // after it is moving, so full-rate streaming has no bubbles.
    assign adv_p2    = !vld_p2 || out_ready;
    assign adv_p1    = !vld_p1 || adv_p2;
    assign in_ready  = adv_p1;
    assign out_valid = vld_p2;

    // Window registers. Out-of-range indices match no channel and are dropped.
    // A compare sitting in S1 sees the values before this edge's write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                win_lo[c] <= '0;
                win_hi[c] <= '0;
            end
            win_en <= '0;
        end else if (cfg_we) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (32'(cfg_ch) == c) begin
                    win_lo[c] <= cfg_lo;
                    win_hi[c] <= cfg_hi;
                    win_en[c] <= cfg_en;
                end
            end
        end
    end

    // ---- S0 -> S1: capture the address ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
        end else if (adv_p1) begin
            vld_p1 <= in_valid;
            if (in_valid)
                addr_p1 <= in_addr;
        end
    end

    // ---- S1 compare logic ----
    always_comb begin
        lt_c  = '0;
        gt_c  = '0;
        hit_c = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            lt_c[c]  = less_than(addr_p1, win_lo[c]);
            gt_c[c]  = less_than(win_hi[c], addr_p1);
            hit_c[c] = win_en[c] & ~lt_c[c] & ~gt_c[c];
        end
    end

    // Lowest-index priority: scan downward so the last assignment wins.
    always_comb begin
        first_c = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (hit_c[c])
                first_c = CH_W'(c);
        end
    end

    assign miss_c = ~|hit_c;

    // ---- S1 -> S2: register results; held while the output is stalled ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2    <= 1'b0;
            out_hit   <= '0;
            out_lt    <= '0;
            out_gt    <= '0;
            out_first <= '0;
            out_miss  <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out_hit   <= hit_c;
                out_lt    <= lt_c;
                out_gt    <= gt_c;
                out_first <= first_c;
                out_miss  <= miss_c;
            end
        end
    end

    // ---- S2 output transfer: violation counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            viol_cnt <= '0;
        else if (viol_clr)
            viol_cnt <= '0;
        else if (out_valid && out_ready && out_miss)
            viol_cnt <= sat_inc(viol_cnt);
    end

endmodule

// File: tb/tb_mem_range_comparator.sv
module tb_mem_range_comparator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_lo = '0;
    logic [15:0] cfg_hi = '0;
    logic        cfg_en = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_addr = '0;
    logic        out_ready = 1'b0;
    logic        viol_clr = 1'b0;

    logic        in_ready_u, out_valid_u, out_miss_u;
    logic [3:0]  out_hit_u, out_lt_u, out_gt_u;
    logic [1:0]  out_first_u;
    logic [1:0]  viol_cnt_u;
    logic        in_ready_s, out_valid_s, out_miss_s;
    logic [3:0]  out_hit_s, out_lt_s, out_gt_s;
    logic [1:0]  out_first_s;
    logic [7:0]  viol_cnt_s;

    mem_range_comparator #(.DATA_W(16), .NUM_CH(4), .SIGNED_MODE(0), .CNT_W(2)) dut_u (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_lo(cfg_lo),
        .cfg_hi(cfg_hi), .cfg_en(cfg_en), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_addr(in_addr), .out_valid(out_valid_u), .out_ready(out_ready),
        .out_hit(out_hit_u), .out_lt(out_lt_u), .out_gt(out_gt_u), .out_first(out_first_u),
        .out_miss(out_miss_u), .viol_clr(viol_clr), .viol_cnt(viol_cnt_u));

    mem_range_comparator #(.DATA_W(16), .NUM_CH(4), .SIGNED_MODE(1), .CNT_W(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_lo(cfg_lo),
        .cfg_hi(cfg_hi), .cfg_en(cfg_en), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_addr(in_addr), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_hit(out_hit_s), .out_lt(out_lt_s), .out_gt(out_gt_s), .out_first(out_first_s),
        .out_miss(out_miss_s), .viol_clr(viol_clr), .viol_cnt(viol_cnt_s));

    always #5 clk = ~clk;

    typedef struct { logic [3:0] hit; logic [3:0] lt; logic [3:0] gt; logic [1:0] first; } res_t;
    typedef struct { res_t u; res_t s; } exp_t;
    typedef struct {
        logic [15:0] addr;
        logic [3:0] hit_u; logic [3:0] lt_u; logic [3:0] gt_u; logic [1:0] first_u;
        logic [3:0] hit_s; logic [3:0] lt_s; logic [3:0] gt_s; logic [1:0] first_s;
    } vec_t;

    res_t  qu[$];
    res_t  qs[$];
    exp_t  pend[$];
    logic [15:0] m_lo [4];
    logic [15:0] m_hi [4];
    logic [3:0]  m_en = '0;
    int    cnt_u = 0;
    int    cnt_s = 0;
    int    n_vec = 0;
    int    n_fail = 0;
    bit    acc_u = 0;
    bit    last_rdy = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_int(input logic [15:0] v, input bit sgn);
        int r;
        r = int'(v);
        if (sgn && r >= 32768)
            r = r - 65536;
        return r;
    endfunction

    // Reference: windows as plain integer ranges.
    function automatic res_t model(input logic [15:0] a, input bit sgn);
        res_t r;
        bit found;
        found = 0;
        r.hit = '0; r.lt = '0; r.gt = '0; r.first = '0;
        for (int c = 0; c < 4; c++) begin
            r.lt[c]  = to_int(a, sgn) < to_int(m_lo[c], sgn);
            r.gt[c]  = to_int(a, sgn) > to_int(m_hi[c], sgn);
            r.hit[c] = m_en[c] && !r.lt[c] && !r.gt[c];
            if (r.hit[c] && !found) begin
                r.first = 2'(c);
                found = 1;
            end
        end
        return r;
    endfunction

    task automatic cmp_res(input string tag, input res_t e, input logic [3:0] hit,
                           input logic [3:0] lt, input logic [3:0] gt,
                           input logic [1:0] first, input logic miss);
        chk({tag, "_hit"},   32'(hit),   32'(e.hit));
        chk({tag, "_lt"},    32'(lt),    32'(e.lt));
        chk({tag, "_gt"},    32'(gt),    32'(e.gt));
        chk({tag, "_first"}, 32'(first), 32'(e.first));
        chk({tag, "_miss"},  32'(miss),  32'(e.hit == 4'd0));
    endtask

    // One clock: called at a negedge with inputs already set.
    task automatic step();
        exp_t p;
        bit   tr_u, tr_s, acc_s;
        #1;
        last_rdy = in_ready_u;
        chk("cnt_u", 32'(viol_cnt_u), 32'(cnt_u));
        chk("cnt_s", 32'(viol_cnt_s), 32'(cnt_s));
        if (out_valid_u) begin
            if (qu.size() == 0) begin
                n_vec++; n_fail++;
                $display("FAIL u_spurious: out_valid=1 expected no result at %0t", $time);
            end else
                cmp_res("u", qu[0], out_hit_u, out_lt_u, out_gt_u, out_first_u, out_miss_u);
        end
        if (out_valid_s) begin
            if (qs.size() == 0) begin
                n_vec++; n_fail++;
                $display("FAIL s_spurious: out_valid=1 expected no result at %0t", $time);
            end else
                cmp_res("s", qs[0], out_hit_s, out_lt_s, out_gt_s, out_first_s, out_miss_s);
        end
        tr_u = out_valid_u && out_ready && (qu.size() > 0);
        tr_s = out_valid_s && out_ready && (qs.size() > 0);
        if (viol_clr) cnt_u = 0;
        else if (tr_u && qu[0].hit == 4'd0) cnt_u = (cnt_u < 3) ? cnt_u + 1 : 3;
        if (viol_clr) cnt_s = 0;
        else if (tr_s && qs[0].hit == 4'd0) cnt_s = (cnt_s < 255) ? cnt_s + 1 : 255;
        if (tr_u) qu.delete(0);
        if (tr_s) qs.delete(0);
        if (cfg_we) begin
            m_lo[cfg_ch] = cfg_lo;
            m_hi[cfg_ch] = cfg_hi;
            m_en[cfg_ch] = cfg_en;
        end
        acc_u = in_valid && in_ready_u;
        acc_s = in_valid && in_ready_s;
        if (acc_u || acc_s) begin
            if (pend.size() > 0) begin
                p = pend[0];
                pend.delete(0);
            end else begin
                p.u = model(in_addr, 0);
                p.s = model(in_addr, 1);
            end
            if (acc_u) qu.push_back(p.u);
            if (acc_s) qs.push_back(p.s);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 0; out_ready = 1; cfg_we = 0; viol_clr = 0;
        while ((qu.size() > 0 || qs.size() > 0) && n < 20) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(qu.size() + qs.size()), 32'd0);
        step();
    endtask

    task automatic wr_cfg(input logic [1:0] ch, input logic [15:0] lo,
                          input logic [15:0] hi, input logic en);
        in_valid = 0;
        cfg_we = 1; cfg_ch = ch; cfg_lo = lo; cfg_hi = hi; cfg_en = en;
        step();
        cfg_we = 0;
    endtask

    task automatic send_one(input logic [15:0] a);
        int n;
        n = 0;
        in_valid = 1; in_addr = a; out_ready = 1;
        do begin
            step();
            n++;
        end while (!acc_u && n < 10);
        chk("send_acc", 32'(acc_u), 32'd1);
        drain();
    endtask

    // Called at a negedge; asserts reset between clock edges.
    task automatic mid_reset();
        #2 rst_n = 0;
        #1;
        chk("rst_vld_u", 32'(out_valid_u), 32'd0);
        chk("rst_vld_s", 32'(out_valid_s), 32'd0);
        chk("rst_cnt_u", 32'(viol_cnt_u), 32'd0);
        chk("rst_cnt_s", 32'(viol_cnt_s), 32'd0);
        chk("rst_hit_u", 32'(out_hit_u), 32'd0);
        chk("rst_miss_u", 32'(out_miss_u), 32'd0);
        qu.delete(); qs.delete(); pend.delete();
        cnt_u = 0; cnt_s = 0; m_en = '0;
        for (int c = 0; c < 4; c++) begin m_lo[c] = '0; m_hi[c] = '0; end
        in_valid = 0; cfg_we = 0; viol_clr = 0; out_ready = 1;
        @(negedge clk);
        rst_n = 1;
        chk("rst_rdy_u", 32'(in_ready_u), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab [10];
        logic [15:0] bp_addr [5];
        int seq [5];
        int idx, cyc, ch;
        logic [15:0] lo, hi;
        exp_t e;

        tab[0] = '{16'h1800, 4'b0101, 4'b1010, 4'b0010, 2'd0, 4'b0101, 4'b1000, 4'b0010, 2'd0};
        tab[1] = '{16'h0FFF, 4'b0000, 4'b1111, 4'b0010, 2'd0, 4'b0000, 4'b1101, 4'b0010, 2'd0};
        tab[2] = '{16'h2800, 4'b0000, 4'b1010, 4'b0111, 2'd0, 4'b0000, 4'b1000, 4'b0111, 2'd0};
        tab[3] = '{16'hFFFF, 4'b0000, 4'b0000, 4'b1111, 2'd0, 4'b0010, 4'b1101, 4'b0000, 2'd1};
        tab[4] = '{16'h8000, 4'b0000, 4'b0010, 4'b1111, 2'd0, 4'b0000, 4'b1111, 4'b0000, 2'd0};
        tab[5] = '{16'h5000, 4'b1000, 4'b0010, 4'b0111, 2'd3, 4'b1000, 4'b0000, 4'b0111, 2'd3};
        tab[6] = '{16'h0080, 4'b0000, 4'b1111, 4'b0000, 2'd0, 4'b0010, 4'b1101, 4'b0000, 2'd1};
        tab[7] = '{16'h1FFF, 4'b0101, 4'b1010, 4'b0010, 2'd0, 4'b0101, 4'b1000, 4'b0010, 2'd0};
        tab[8] = '{16'h1000, 4'b0001, 4'b1110, 4'b0010, 2'd0, 4'b0001, 4'b1100, 4'b0010, 2'd0};
        tab[9] = '{16'h27FF, 4'b0100, 4'b1010, 4'b0011, 2'd2, 4'b0100, 4'b1000, 4'b0011, 2'd2};
        bp_addr = '{16'h1800, 16'h0FFF, 16'h2800, 16'h5000, 16'hFFFF};
        seq = '{1, 2, 3, 3, 3};
        for (int c = 0; c < 4; c++) begin m_lo[c] = '0; m_hi[c] = '0; end

        // Reset state
        repeat (3) @(negedge clk);
        chk("init_vld_u", 32'(out_valid_u), 32'd0);
        chk("init_vld_s", 32'(out_valid_s), 32'd0);
        chk("init_cnt_u", 32'(viol_cnt_u), 32'd0);
        chk("init_hit_u", 32'(out_hit_u), 32'd0);
        chk("init_first_u", 32'(out_first_u), 32'd0);
        rst_n = 1;
        chk("init_rdy_u", 32'(in_ready_u), 32'd1);

        // Fixed windows, table vectors streamed at full rate
        wr_cfg(2'd0, 16'h1000, 16'h1FFF, 1'b1);
        wr_cfg(2'd1, 16'hFF00, 16'h00FF, 1'b1);
        wr_cfg(2'd2, 16'h1800, 16'h27FF, 1'b1);
        wr_cfg(2'd3, 16'h5000, 16'h5000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            e.u = '{tab[i].hit_u, tab[i].lt_u, tab[i].gt_u, tab[i].first_u};
            e.s = '{tab[i].hit_s, tab[i].lt_s, tab[i].gt_s, tab[i].first_s};
            pend.push_back(e);
        end
        out_ready = 1;
        idx = 0; cyc = 0;
        while (idx < 10 && cyc < 30) begin
            in_valid = 1; in_addr = tab[idx].addr;
            step();
            chk("full_rate", 32'(acc_u), 32'd1);
            if (acc_u) idx++;
            cyc++;
        end
        drain();

        // Backpressure: 3 stalled cycles while streaming 5 addresses
        idx = 0; cyc = 0;
        while (idx < 5 && cyc < 30) begin
            in_valid = 1; in_addr = bp_addr[idx]; out_ready = (cyc >= 3);
            step();
            if (cyc == 2) chk("bp_rdy_drop", 32'(last_rdy), 32'd0);
            if (acc_u) idx++;
            cyc++;
        end
        chk("bp_all_acc", 32'(idx), 32'd5);
        drain();

        // Saturating counter with all windows disabled
        mid_reset();
        for (int i = 0; i < 5; i++) begin
            send_one(16'h4000 + 16'(i));
            chk("viol_seq", 32'(viol_cnt_u), 32'(seq[i]));
        end
        in_valid = 1; in_addr = 16'h4321; out_ready = 1;
        step();
        chk("clr_acc", 32'(acc_u), 32'd1);
        in_valid = 0;
        chk("lat_vld_c1", 32'(out_valid_u), 32'd0);
        step();
        chk("lat_vld_c2", 32'(out_valid_u), 32'd1);
        viol_clr = 1;
        step();
        viol_clr = 0;
        chk("clr_wins", 32'(viol_cnt_u), 32'd0);

        // Reset with both stages full
        send_one(16'h0000);
        in_valid = 1; out_ready = 0; in_addr = 16'h0010;
        step();
        in_addr = 16'h0020;
        step();
        chk("fill_rdy", 32'(in_ready_u), 32'd0);
        mid_reset();
        e.u = '{4'b0000, 4'b0000, 4'b0000, 2'd0};
        e.s = e.u;
        pend.push_back(e);
        send_one(16'h0000);
        chk("post_rst_cnt", 32'(viol_cnt_u), 32'd1);

        // Config write racing a compare in S1
        mid_reset();
        wr_cfg(2'd0, 16'h1000, 16'h1FFF, 1'b1);
        e.u = '{4'b0001, 4'b0000, 4'b1110, 2'd0};
        e.s = e.u;
        pend.push_back(e);
        e.u = '{4'b0000, 4'b0000, 4'b1110, 2'd0};
        e.s = e.u;
        pend.push_back(e);
        in_valid = 1; in_addr = 16'h1234; out_ready = 1;
        step();
        chk("race_acc", 32'(acc_u), 32'd1);
        cfg_we = 1; cfg_ch = 2'd0; cfg_lo = 16'h1000; cfg_hi = 16'h1FFF; cfg_en = 1'b0;
        step();
        cfg_we = 0;
        drain();

        // Random windows and traffic against the reference model
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 4; c++) begin
                lo = 16'($urandom);
                hi = ($urandom_range(0, 1) != 0) ? lo + 16'($urandom_range(0, 255)) : 16'($urandom);
                wr_cfg(2'(c), lo, hi, $urandom_range(0, 3) != 0);
            end
            for (int k = 0; k < 60; k++) begin
                in_valid = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 1) != 0)
                    in_addr = 16'($urandom);
                else begin
                    ch = $urandom_range(0, 3);
                    in_addr = (($urandom_range(0, 1) != 0) ? m_lo[ch] : m_hi[ch])
                              + 16'($urandom_range(0, 2)) - 16'd1;
                end
                out_ready = ($urandom_range(0, 9) < 7);
                viol_clr = ($urandom_range(0, 19) == 0);
                step();
            end
            viol_clr = 0;
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
